// File: rtl/similarity_pkg.sv
// Shared types and helpers for the segmented hypervector similarity engine.
package similarity_pkg;

  typedef enum logic {
    SIM_OVERLAP = 1'b0,
    SIM_HAMMING = 1'b1
  } sim_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } sim_state_t;

  // Bits needed to hold a population count of n bits (0..n inclusive).
  function automatic int popcount_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sim_lane_popcount.sv
// One lane: AND (overlap) or XOR (Hamming) of two segments, then popcount.
module sim_lane_popcount
  import similarity_pkg::*;
#(
  parameter int LENGTH_SEGMENT = 32,
  localparam int LW = popcount_width(LENGTH_SEGMENT)
) (
  input  logic [LENGTH_SEGMENT-1:0] a,
  input  logic [LENGTH_SEGMENT-1:0] b,
  input  sim_mode_t                 mode,
  output logic [LW-1:0]             count
);

  logic [LENGTH_SEGMENT-1:0] bits;

  always_comb begin
    bits  = (mode == SIM_HAMMING) ? (a ^ b) : (a & b);
    count = '0;
    for (int i = 0; i < LENGTH_SEGMENT; i++) begin
      count = count + LW'(bits[i]);
    end
  end

endmodule

// File: rtl/similarity_segmented.sv
// Streams NB_LANES segments of two hypervectors per beat through a two-stage
// popcount/accumulate pipeline and reports the full-vector similarity count.
module similarity_segmented
  import similarity_pkg::*;
#(
  parameter int D              = 1024,
  parameter int LENGTH_SEGMENT = 32,
  parameter int NB_LANES       = 2,
  localparam int CW = popcount_width(D)
) (
  input  logic                               clk,
  input  logic                               arst_n_in,
  input  logic                               start_new_hv,
  input  logic                               mode,
  input  logic [CW-1:0]                      threshold,
  input  logic                               abort,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NB_LANES*LENGTH_SEGMENT-1:0] segment_hv_a,
  input  logic [NB_LANES*LENGTH_SEGMENT-1:0] segment_hv_b,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [CW-1:0]                      sim_count,
  output logic                               above_thr,
  output logic                               busy
);

  localparam int SEG_W = NB_LANES * LENGTH_SEGMENT;
  localparam int BEATS = D / SEG_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = popcount_width(LENGTH_SEGMENT);
  localparam int SW    = popcount_width(SEG_W);

  if ((D % SEG_W) != 0) begin : g_bad_cfg
    $error("similarity_segmented: D must be a multiple of LENGTH_SEGMENT*NB_LANES");
  end

  // Handshakes: a beat moves when in_valid && in_ready, a result is consumed
  // when result_valid && result_ready; a producer holds data until it moves.

  sim_state_t     state;
  sim_state_t     state_next;
  sim_mode_t      mode_q;
  logic [CW-1:0]  thr_q;
  logic [BCW-1:0] beat_cnt;
  logic [CW-1:0]  acc;
  logic [SW-1:0]  s1_sum;
  logic           s1_valid;
  logic           s2_valid;
  logic [SW-1:0]  lane_sum;
  logic [LW-1:0]  lane_cnt [NB_LANES];
  logic           beat_fire;
  logic           last_beat;
  logic           abort_hit;
  logic           start_hit;

  for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
    sim_lane_popcount #(.LENGTH_SEGMENT(LENGTH_SEGMENT)) u_lane (
      .a     (segment_hv_a[l*LENGTH_SEGMENT +: LENGTH_SEGMENT]),
      .b     (segment_hv_b[l*LENGTH_SEGMENT +: LENGTH_SEGMENT]),
      .mode  (mode_q),
      .count (lane_cnt[l])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < NB_LANES; l++) begin
      lane_sum = lane_sum + SW'(lane_cnt[l]);
    end
  end

  assign in_ready     = (state == ACCUM);
  assign result_valid = (state == RESULT);
  assign busy         = (state != IDLE);
  assign beat_fire    = in_valid && in_ready;
  assign last_beat    = (beat_cnt == BCW'(BEATS - 1));
  assign abort_hit    = abort && (state != IDLE);
  assign start_hit    = start_new_hv && (state == IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_new_hv) state_next = ACCUM;
      ACCUM:   if (beat_fire && last_beat) state_next = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_next = RESULT;
      RESULT:  if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mode_q   <= SIM_OVERLAP;
      thr_q    <= '0;
      beat_cnt <= '0;
      acc      <= '0;
      s1_sum   <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (start_hit) begin
      mode_q   <= sim_mode_t'(mode);
      thr_q    <= threshold;
      beat_cnt <= '0;
      acc      <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (abort_hit) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= beat_fire;
      s2_valid <= s1_valid;
      if (beat_fire) begin
        s1_sum   <= lane_sum;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (s1_valid) acc <= acc + CW'(s1_sum);
    end
  end

  // Result outputs load on the DRAIN->RESULT step and then hold through IDLE.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      sim_count <= '0;
      above_thr <= 1'b0;
    end else if (start_hit) begin
      sim_count <= '0;
      above_thr <= 1'b0;
    end else if (state == DRAIN && state_next == RESULT) begin
      sim_count <= acc;
      above_thr <= (acc >= thr_q);
    end
  end

endmodule

// File: tb/tb_similarity_segmented.sv
// Directed bench for similarity_segmented with a scoreboard of expected results.
module tb_similarity_segmented;

  localparam int D     = 1024;
  localparam int LS    = 32;
  localparam int NL    = 2;
  localparam int SEG_W = LS * NL;
  localparam int BEATS = D / SEG_W;
  localparam int CW    = $clog2(D + 1);

  logic             clk = 1'b0;
  logic             arst_n_in;
  logic             start_new_hv;
  logic             mode;
  logic [CW-1:0]    threshold;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [SEG_W-1:0] segment_hv_a;
  logic [SEG_W-1:0] segment_hv_b;
  logic             result_valid;
  logic             result_ready;
  logic [CW-1:0]    sim_count;
  logic             above_thr;
  logic             busy;

  logic [CW:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  time         start_t;
  time         last_acc_t;
  int          gaps_total;

  always #5 clk = ~clk;

  similarity_segmented #(.D(D), .LENGTH_SEGMENT(LS), .NB_LANES(NL)) dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .start_new_hv (start_new_hv),
    .mode         (mode),
    .threshold    (threshold),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .segment_hv_a (segment_hv_a),
    .segment_hv_b (segment_hv_b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sim_count    (sim_count),
    .above_thr    (above_thr),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void beat_data(input int pat, input int k,
                                    output logic [SEG_W-1:0] a, output logic [SEG_W-1:0] b);
    logic [31:0] kk;
    kk = 32'(k);
    case (pat)
      0:       begin a = '1; b = '1; end
      1:       begin a = '1; b = {NL{32'h5555_5555}}; end
      2:       begin a = {32'h0, 32'h0000_000F}; b = {32'h0, 32'h0000_00FF}; end
      default: begin
        a = {kk * 32'h9E37_79B9, 32'hA5A5_0000 | kk};
        b = {32'hFFFF_0000 ^ kk, kk * 32'd7 + 32'h0F0F_0F0F};
      end
    endcase
  endfunction

  function automatic logic [CW:0] model(input int pat, input logic md, input int thr);
    logic [SEG_W-1:0] a, b;
    int cnt;
    cnt = 0;
    for (int k = 0; k < BEATS; k++) begin
      beat_data(pat, k, a, b);
      cnt += md ? $countones(a ^ b) : $countones(a & b);
    end
    return {(cnt >= thr), CW'(cnt)};
  endfunction

  task automatic start_run(input logic md, input int thr, input int pat, input bit push);
    mode         = md;
    threshold    = CW'(thr);
    start_new_hv = 1'b1;
    if (push) exp_q.push_back(model(pat, md, thr));
    @(posedge clk);
    start_t = $time;
    #1 start_new_hv = 1'b0;
  endtask

  task automatic send_beats(input int pat, input int first, input int last, input bit gaps);
    logic [SEG_W-1:0] a, b;
    int g;
    int n;
    for (int k = first; k <= last; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
        gaps_total += g;
      end
      beat_data(pat, k, a, b);
      segment_hv_a = a;
      segment_hv_b = b;
      in_valid     = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        n++;
        if (n > 20) begin
          check("in_ready_timeout", 32'(in_ready), 32'd1);
          break;
        end
      end
      @(posedge clk);
      last_acc_t = $time;
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, input int exp_edges);
    logic [CW:0] e;
    time rise_t;
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (result_valid) break;
      n++;
      if (n > 40) begin
        check("result_timeout", 32'(result_valid), 32'd1);
        break;
      end
    end
    rise_t = $time - 5;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("latency_last_beat", 32'((rise_t - last_acc_t) / 10), 32'd3);
    check("cycles_from_start", 32'((rise_t - start_t) / 10), 32'(exp_edges));
    if (hold > 0) begin
      start_new_hv = 1'b1;
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", 32'(result_valid), 32'd1);
        check("hold_count", 32'(sim_count), 32'(e[CW-1:0]));
        check("hold_above", 32'(above_thr), 32'(e[CW]));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      result_ready = 1'b1;
    end
    check("sim_count", 32'(sim_count), 32'(e[CW-1:0]));
    check("above_thr", 32'(above_thr), 32'(e[CW]));
    @(posedge clk);
    #1 start_new_hv = 1'b0;
    check("handoff_valid_low", 32'(result_valid), 32'd0);
    check("handoff_idle", 32'(busy), 32'd0);
    check("idle_count_kept", 32'(sim_count), 32'(e[CW-1:0]));
    @(posedge clk);
    #1;
    check("handoff_start_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    arst_n_in    = 1'b0;
    start_new_hv = 1'b0;
    mode         = 1'b0;
    threshold    = '0;
    abort        = 1'b0;
    in_valid     = 1'b0;
    segment_hv_a = '0;
    segment_hv_b = '0;
    result_ready = 1'b1;
    gaps_total   = 0;
    last_acc_t   = 0;
    start_t      = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_sim_count", 32'(sim_count), 32'd0);
    check("rst_above_thr", 32'(above_thr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;

    // Overlap, all ones.
    start_run(1'b0, 512, 0, 1'b1);
    check("busy_after_start", 32'(busy), 32'd1);
    send_beats(0, 0, BEATS - 1, 1'b0);
    get_result(0, BEATS + 3);

    // Hamming against alternating pattern, threshold on both sides.
    start_run(1'b1, 512, 1, 1'b1);
    send_beats(1, 0, BEATS - 1, 1'b0);
    get_result(0, BEATS + 3);
    start_run(1'b1, 513, 1, 1'b1);
    send_beats(1, 0, BEATS - 1, 1'b0);
    get_result(0, BEATS + 3);

    // Sparse overlap with random in_valid gaps.
    gaps_total = 0;
    start_run(1'b0, 64, 2, 1'b1);
    send_beats(2, 0, BEATS - 1, 1'b1);
    get_result(0, BEATS + 3 + gaps_total);

    // Result backpressure for 10 cycles with start_new_hv held high.
    result_ready = 1'b0;
    start_run(1'b0, 100, 3, 1'b1);
    send_beats(3, 0, BEATS - 1, 1'b0);
    get_result(10, BEATS + 3);
    result_ready = 1'b1;

    // Abort after beat 7, then a clean full run.
    start_run(1'b0, 512, 0, 1'b0);
    send_beats(0, 0, 7, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("abort_no_result", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    start_run(1'b1, 300, 3, 1'b1);
    send_beats(3, 0, BEATS - 1, 1'b0);
    get_result(0, BEATS + 3);

    // Asynchronous reset during beat 5, then a full run.
    start_run(1'b0, 512, 3, 1'b0);
    send_beats(3, 0, 4, 1'b0);
    in_valid = 1'b1;
    #2 arst_n_in = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_count", 32'(sim_count), 32'd0);
    check("mid_rst_above", 32'(above_thr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    start_run(1'b0, 200, 3, 1'b1);
    send_beats(3, 0, BEATS - 1, 1'b0);
    get_result(0, BEATS + 3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
